// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage with PC, 2-entry output buffer and redirect/flush.
// Optional macro CONTADOR_BUSCA_EN adds pop/redirect event counters.
module unidade_busca #(
    parameter logic [31:0] PC_INICIAL  = 32'd0,
    parameter int          LARGURA_END = 8
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] endereco_mem,
    input  logic [31:0] instrucao_mem,
    input  logic        desvio_valido,
    input  logic [31:0] desvio_alvo,
    output logic        saida_valida,
    input  logic        saida_pronta,
    output logic [31:0] instrucao_saida,
    output logic [31:0] pc_saida
`ifdef CONTADOR_BUSCA_EN
    ,
    output logic [31:0] contador_instr,
    output logic [31:0] contador_desvio
`endif
);

    typedef logic [LARGURA_END-1:0] pc_t;

    pc_t         pc_q, pc_d;
    pc_t         pc_pend_q, pc_pend_d;
    logic        pendente_q, pendente_d;
    logic [1:0]  count_q, count_d;
    pc_t         buf_pc_q [2];
    pc_t         buf_pc_d [2];
    logic [31:0] buf_ins_q [2];
    logic [31:0] buf_ins_d [2];

    logic        pop;
    logic        emite;
    logic [2:0]  ocupacao;
    logic [1:0]  base;

    assign saida_valida    = (count_q != 2'd0);
    assign pop             = saida_valida & saida_pronta;
    assign instrucao_saida = buf_ins_q[0];
    assign pc_saida        = 32'(buf_pc_q[0]);
    assign endereco_mem    = 32'(pc_q);

    // Credit: buffered + in-flight after this pop must leave room for one more.
    assign ocupacao = {1'b0, count_q} + {2'b0, pendente_q} - {2'b0, pop};
    assign emite    = !reset && !desvio_valido && (ocupacao < 3'd2);

    // PC advance, redirect and in-flight request tracking.
    always_comb begin
        pc_d       = pc_q;
        pc_pend_d  = pc_pend_q;
        pendente_d = 1'b0;
        if (desvio_valido) begin
            pc_d = pc_t'(desvio_alvo);
        end else if (emite) begin
            pc_d       = pc_q + pc_t'(1);
            pc_pend_d  = pc_q;
            pendente_d = 1'b1;
        end
    end

    // Shift FIFO: pop moves entry 1 to head, memory response lands behind.
    always_comb begin
        buf_pc_d  = buf_pc_q;
        buf_ins_d = buf_ins_q;
        base      = count_q - {1'b0, pop};
        if (pop) begin
            buf_pc_d[0]  = buf_pc_q[1];
            buf_ins_d[0] = buf_ins_q[1];
        end
        if (pendente_q) begin
            buf_pc_d[base[0]]  = pc_pend_q;
            buf_ins_d[base[0]] = instrucao_mem;
        end
        count_d = base + {1'b0, pendente_q};
        if (desvio_valido) begin
            count_d = 2'd0;
        end
    end

    // State registers; reset wins over redirect and issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q         <= pc_t'(PC_INICIAL);
            pc_pend_q    <= '0;
            pendente_q   <= 1'b0;
            count_q      <= 2'd0;
            buf_pc_q[0]  <= '0;
            buf_pc_q[1]  <= '0;
            buf_ins_q[0] <= '0;
            buf_ins_q[1] <= '0;
        end else begin
            pc_q       <= pc_d;
            pc_pend_q  <= pc_pend_d;
            pendente_q <= pendente_d;
            count_q    <= count_d;
            buf_pc_q   <= buf_pc_d;
            buf_ins_q  <= buf_ins_d;
        end
    end

`ifdef CONTADOR_BUSCA_EN
    logic [31:0] contador_instr_q, contador_instr_d;
    logic [31:0] contador_desvio_q, contador_desvio_d;

    assign contador_instr  = contador_instr_q;
    assign contador_desvio = contador_desvio_q;

    // Event counters: one per handshake, one per redirect.
    always_comb begin
        contador_instr_d  = contador_instr_q + {31'd0, pop};
        contador_desvio_d = contador_desvio_q + {31'd0, desvio_valido};
    end

    // Counter registers clear on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador_instr_q  <= '0;
            contador_desvio_q <= '0;
        end else begin
            contador_instr_q  <= contador_instr_d;
            contador_desvio_q <= contador_desvio_d;
        end
    end
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed and random checks of unidade_busca against
// a stream scoreboard (expected next PC per handshake) and a 1-cycle memory.
module tb_unidade_busca;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        desvio_valido;
    logic [31:0] desvio_alvo;
    logic        saida_pronta;
    logic [31:0] endereco_mem;
    logic [31:0] instrucao_mem;
    logic        saida_valida;
    logic [31:0] instrucao_saida;
    logic [31:0] pc_saida;

    logic        reset2;
    logic        pronta2;
    logic [31:0] endereco2;
    logic [31:0] mem2;
    logic        valida2;
    logic [31:0] instr2;
    logic [31:0] pc2;

`ifdef CONTADOR_BUSCA_EN
    logic [31:0] c_instr;
    logic [31:0] c_desv;
    logic [31:0] c2_instr;
    logic [31:0] c2_desv;
`endif

    unidade_busca #(.PC_INICIAL(32'd0), .LARGURA_END(8)) dut (
        .clock           (clk),
        .reset           (reset),
        .endereco_mem    (endereco_mem),
        .instrucao_mem   (instrucao_mem),
        .desvio_valido   (desvio_valido),
        .desvio_alvo     (desvio_alvo),
        .saida_valida    (saida_valida),
        .saida_pronta    (saida_pronta),
        .instrucao_saida (instrucao_saida),
        .pc_saida        (pc_saida)
`ifdef CONTADOR_BUSCA_EN
        ,
        .contador_instr  (c_instr),
        .contador_desvio (c_desv)
`endif
    );

    unidade_busca #(.PC_INICIAL(32'd254), .LARGURA_END(8)) dut2 (
        .clock           (clk),
        .reset           (reset2),
        .endereco_mem    (endereco2),
        .instrucao_mem   (mem2),
        .desvio_valido   (1'b0),
        .desvio_alvo     (32'd0),
        .saida_valida    (valida2),
        .saida_pronta    (pronta2),
        .instrucao_saida (instr2),
        .pc_saida        (pc2)
`ifdef CONTADOR_BUSCA_EN
        ,
        .contador_instr  (c2_instr),
        .contador_desvio (c2_desv)
`endif
    );

    // Instruction memory model: mem[i] = A000_0000 + i, registered read.
    always @(posedge clk) instrucao_mem <= 32'hA000_0000 + endereco_mem;
    always @(posedge clk) mem2 <= 32'hA000_0000 + endereco2;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = 32'd0;
    int          pops = 0;
    int          desvios = 0;
    bit          prev_dv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive inputs, score the handshake, advance one cycle.
    task automatic step(input bit rdy, input bit dv, input logic [31:0] alvo);
        saida_pronta  = rdy;
        desvio_valido = dv;
        desvio_alvo   = alvo;
        chk("addr_hi_zero", endereco_mem & 32'hFFFF_FF00, 32'd0);
        if (prev_dv) chk("flush_valid", {31'd0, saida_valida}, 32'd0);
        if (reset) begin
            exp_pc  = 32'd0;
            pops    = 0;
            desvios = 0;
        end else begin
            if (saida_valida && rdy) begin
                chk("stream_pc", pc_saida, exp_pc);
                chk("stream_instr", instrucao_saida, 32'hA000_0000 + exp_pc);
                exp_pc = (exp_pc + 32'd1) & 32'hFF;
                pops++;
            end
            if (dv) begin
                exp_pc = alvo & 32'hFF;
                desvios++;
            end
        end
        prev_dv = dv && !reset;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bool_init: begin
            reset         = 1'b1;
            reset2        = 1'b1;
            pronta2       = 1'b1;
            desvio_valido = 1'b0;
            desvio_alvo   = 32'd0;
            saida_pronta  = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", {31'd0, saida_valida}, 32'd0);
        chk("rst_instr", instrucao_saida, 32'd0);
        chk("rst_pc", pc_saida, 32'd0);
        chk("rst_addr", endereco_mem, 32'd0);

        // Fill latency and streaming
        reset = 1'b0;
        step(1, 0, 0);
        chk("lat_valid0", {31'd0, saida_valida}, 32'd0);
        chk("lat_addr", endereco_mem, 32'd1);
        step(1, 0, 0);
        chk("lat_valid1", {31'd0, saida_valida}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("run_valid", {31'd0, saida_valida}, 32'd1);
            step(1, 0, 0);
        end

        // Stall then release
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        step(1, 0, 0);
        step(1, 0, 0);
        chk("stall_first_valid", {31'd0, saida_valida}, 32'd1);
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            chk("stall_addr", endereco_mem, 32'd3);
            chk("stall_valid", {31'd0, saida_valida}, 32'd1);
            step(0, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            chk("release_valid", {31'd0, saida_valida}, 32'd1);
            step(1, 0, 0);
        end

        // Redirect while head pc = 5
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 20 && !(saida_valida && pc_saida == 32'd5); i++)
            step(1, 0, 0);
        chk("reach_pc5", pc_saida, 32'd5);
        step(1, 1, 32'h40);
        chk("redir_v0", {31'd0, saida_valida}, 32'd0);
        step(1, 0, 0);
        chk("redir_v1", {31'd0, saida_valida}, 32'd0);
        step(1, 0, 0);
        chk("redir_v2", {31'd0, saida_valida}, 32'd1);
        chk("redir_pc", pc_saida, 32'h40);
        chk("redir_instr", instrucao_saida, 32'hA000_0040);
        for (int i = 0; i < 4; i++) step(1, 0, 0);

        // Reset with a full buffer
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        chk("full_valid", {31'd0, saida_valida}, 32'd1);
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        chk("rst_full_valid", {31'd0, saida_valida}, 32'd0);
        chk("rst_full_addr", endereco_mem, 32'd0);
        chk("rst_full_pc", pc_saida, 32'd0);
        chk("rst_full_instr", instrucao_saida, 32'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // PC wrap with PC_INICIAL = 254
        reset2 = 1'b0;
        @(negedge clk);
        chk("wrap_valid0", {31'd0, valida2}, 32'd0);
        chk("wrap_addr", endereco2, 32'd255);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_valid", {31'd0, valida2}, 32'd1);
            chk("wrap_pc", pc2, (32'd254 + 32'(i)) & 32'hFF);
            chk("wrap_instr", instr2, 32'hA000_0000 + ((32'd254 + 32'(i)) & 32'hFF));
            chk("wrap_addr_hi", endereco2 & 32'hFFFF_FF00, 32'd0);
            @(negedge clk);
        end

`ifdef CONTADOR_BUSCA_EN
        // Event counters
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        chk("cnt_rst_instr", c_instr, 32'd0);
        chk("cnt_rst_desv", c_desv, 32'd0);
        for (int i = 0; i < 40 && pops < 10; i++)
            step(1, (i == 4 || i == 9), 32'h10 + 32'(i));
        chk("cnt_pops_model", 32'(pops), 32'd10);
        chk("cnt_instr", c_instr, 32'(pops));
        chk("cnt_desv", c_desv, 32'd2);
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        chk("cnt_clr_instr", c_instr, 32'd0);
        chk("cnt_clr_desv", c_desv, 32'd0);
`endif

        // Random handshake and redirect traffic
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        p0 = pops;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        chk("rand_progress", {31'd0, (pops - p0) >= 100}, 32'd1);
`ifdef CONTADOR_BUSCA_EN
        chk("rand_cnt_instr", c_instr, 32'(pops));
        chk("rand_cnt_desv", c_desv, 32'(desvios));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
